// File: rtl/mod_addsub_pipe.sv
// Modular add/subtract, 2-stage valid/ready pipeline.
// Stage 1 forms the raw sum/difference; stage 2 applies the single modulus correction.
// Carries use grouped lookahead (CLA_GROUP bits per group), rippling between groups.
module mod_addsub_pipe #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CLA_GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int unsigned N_GRP = WIDTH / CLA_GROUP;

   // Grouped carry-lookahead adder: returns {carry_out, sum}.
   function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
      logic [WIDTH-1:0] p, g, s;
      logic             c_grp, c_bit, pp;
      int               base;
      p     = x ^ y;
      g     = x & y;
      s     = '0;
      c_grp = cin;
      for (int grp = 0; grp < int'(N_GRP); grp++) begin
         base = grp * int'(CLA_GROUP);
         // carry into each bit as a sum of products of the group's g/p and group carry-in
         for (int j = 0; j < int'(CLA_GROUP); j++) begin
            c_bit = 1'b0;
            pp    = 1'b1;
            for (int k = j - 1; k >= 0; k--) begin
               c_bit = c_bit | (pp & g[base + k]);
               pp    = pp & p[base + k];
            end
            c_bit        = c_bit | (pp & c_grp);
            s[base + j]  = p[base + j] ^ c_bit;
         end
         // group carry-out from group generate/propagate
         c_bit = 1'b0;
         pp    = 1'b1;
         for (int k = int'(CLA_GROUP) - 1; k >= 0; k--) begin
            c_bit = c_bit | (pp & g[base + k]);
            pp    = pp & p[base + k];
         end
         c_grp = c_bit | (pp & c_grp);
      end
      return {c_grp, s};
   endfunction

   logic             v1_q, v1_d, v2_q, v2_d;
   logic [WIDTH:0]   raw_q, raw_d;
   logic             borrow_q, borrow_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic             e_q, e_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;

   logic             s1_adv, s2_adv;
   logic [WIDTH:0]   sum1;
   logic [WIDTH:0]   corr;
   logic             apply_corr;
   logic [WIDTH-1:0] res_c;

   // Handshake: a stage advances when it is empty or its successor advances.
   always_comb begin
      s2_adv = !v2_q || out_ready;
      s1_adv = !v1_q || s2_adv;
   end

   assign in_ready = s1_adv && !rst;

   // Stage 1 datapath: a + b, or a + ~b + 1 for subtract.
   always_comb begin
      sum1 = cla_add(a, op ? ~b : b, op);
   end

   // Stage 2 datapath: one adder does either raw - n (add) or raw + n (sub).
   always_comb begin
      corr       = cla_add(raw_q[WIDTH-1:0], op_q ? n_q : ~n_q, !op_q);
      // for add, raw >= n exactly when raw[WIDTH] is set or the low subtraction carries out
      apply_corr = op_q ? borrow_q : (raw_q[WIDTH] | corr[WIDTH]);
      res_c      = apply_corr ? corr[WIDTH-1:0] : raw_q[WIDTH-1:0];
   end

   // Next-state for both stages; registers hold unless their stage advances.
   always_comb begin
      v1_d     = v1_q;
      raw_d    = raw_q;
      borrow_d = borrow_q;
      op_d     = op_q;
      n_d      = n_q;
      e_d      = e_q;
      v2_d     = v2_q;
      result_d = result_q;
      err_d    = err_q;
      if (s1_adv) begin
         v1_d = in_valid;
         if (in_valid) begin
            raw_d    = sum1;
            borrow_d = op & ~sum1[WIDTH];
            op_d     = op;
            n_d      = n;
            e_d      = (n == '0) || (a >= n) || (b >= n);
         end
      end
      if (s2_adv) begin
         v2_d = v1_q;
         if (v1_q) begin
            result_d = e_q ? '0 : res_c;
            err_d    = e_q;
         end
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         raw_q    <= '0;
         borrow_q <= 1'b0;
         op_q     <= 1'b0;
         n_q      <= '0;
         e_q      <= 1'b0;
         v2_q     <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         raw_q    <= raw_d;
         borrow_q <= borrow_d;
         op_q     <= op_d;
         n_q      <= n_d;
         e_q      <= e_d;
         v2_q     <= v2_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign out_valid = v2_q;
   assign result    = result_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe against an arithmetic reference queue.
module tb_mod_addsub_pipe;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, op, out_valid, out_ready, err;
   logic [W-1:0] a, b, n, result;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W:0]   exp_q[$];
   logic         stall_hold = 1'b0;
   logic [W-1:0] held_r;
   logic         held_e;

   mod_addsub_pipe #(.WIDTH(W), .CLA_GROUP(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .n(n), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: {err, result} from the modular arithmetic definition.
   function automatic logic [W:0] model(input logic o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic [W-1:0] m);
      int unsigned ix, iy, im;
      ix = x; iy = y; im = m;
      if (im == 0 || ix >= im || iy >= im) return {1'b1, 8'd0};
      if (!o) return {1'b0, W'((ix + iy) % im)};
      return {1'b0, W'((ix + im - iy) % im)};
   endfunction

   // Monitor: sample between edges, track transfers, check order and stall stability.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_hold = 1'b0;
      end else begin
         if (stall_hold) begin
            check_eq("stall_valid_hold", 32'(out_valid), 32'd1);
            check_eq("stall_result_hold", 32'(result), 32'(held_r));
            check_eq("stall_err_hold", 32'(err), 32'(held_e));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("out_without_input", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               check_eq("stream_result", 32'(result), 32'(e[W-1:0]));
               check_eq("stream_err", 32'(err), 32'(e[W]));
            end
         end
         stall_hold = out_valid && !out_ready;
         held_r     = result;
         held_e     = err;
         if (in_valid && in_ready) exp_q.push_back(model(op, a, b, n));
      end
   end

   // Present one operation; returns at posedge+1 just after it was accepted.
   task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] m);
      int t;
      t = 0;
      op = o; a = x; b = y; n = m; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Directed op through an empty pipeline: checks latency and the exact value.
   task automatic op_expect(input string tag, input logic o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] m,
                            input logic [W-1:0] er, input logic ee);
      out_ready = 1'b1;
      send(o, x, y, m);
      check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq({tag, "_lat2"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_result"}, 32'(result), 32'(er));
      check_eq({tag, "_err"}, 32'(err), 32'(ee));
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = 1'b0; a = '0; b = '0; n = 8'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_result", 32'(result), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      op_expect("add_200_100", 1'b0, 8'd200, 8'd100, 8'd251, 8'd49, 1'b0);
      op_expect("add_250_250", 1'b0, 8'd250, 8'd250, 8'd251, 8'd249, 1'b0);
      op_expect("sub_5_9", 1'b1, 8'd5, 8'd9, 8'd13, 8'd9, 1'b0);
      op_expect("sub_9_5", 1'b1, 8'd9, 8'd5, 8'd13, 8'd4, 1'b0);
      op_expect("sub_7_7", 1'b1, 8'd7, 8'd7, 8'd13, 8'd0, 1'b0);
      op_expect("add_n1", 1'b0, 8'd0, 8'd0, 8'd1, 8'd0, 1'b0);
      op_expect("err_a_eq_n", 1'b0, 8'd13, 8'd2, 8'd13, 8'd0, 1'b1);
      op_expect("err_n0", 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
      op_expect("after_err", 1'b0, 8'd1, 8'd2, 8'd5, 8'd3, 1'b0);
      drain();

      // Backpressure: two accepts fill the pipe, then in_ready drops.
      out_ready = 1'b0;
      send(1'b0, 8'd1, 8'd1, 8'd251);
      send(1'b0, 8'd2, 8'd2, 8'd251);
      op = 1'b0; a = 8'd3; b = 8'd3; n = 8'd251; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
         check_eq("bp_out_valid", 32'(out_valid), 32'd1);
         check_eq("bp_head_result", 32'(result), 32'd2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_in_ready_comb", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      send(1'b0, 8'd4, 8'd4, 8'd251);
      drain();

      // Streaming: one accept and one result per cycle after the fill.
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         n  = W'($urandom_range(1, 255));
         a  = W'($urandom_range(0, 32'(n) - 1));
         b  = W'($urandom_range(0, 32'(n) - 1));
         op = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         @(negedge clk);
         check_eq("stream_in_ready", 32'(in_ready), 32'd1);
         if (i >= 2) check_eq("stream_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
      end
      drain();

      // Random traffic with random backpressure and occasional range errors.
      for (int i = 0; i < 80; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         n  = W'($urandom_range(0, 255));
         op = 1'($urandom_range(0, 1));
         if (n != 0 && $urandom_range(0, 7) != 0) begin
            a = W'($urandom_range(0, 32'(n) - 1));
            b = W'($urandom_range(0, 32'(n) - 1));
         end else begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
         end
         @(posedge clk); #1;
      end
      drain();

      // Reset with both stages full.
      out_ready = 1'b0;
      send(1'b0, 8'd10, 8'd20, 8'd100);
      send(1'b0, 8'd30, 8'd40, 8'd100);
      rst = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_in_ready2", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("relrst_in_ready", 32'(in_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check_eq("relrst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      op_expect("after_rst", 1'b1, 8'd9, 8'd5, 8'd13, 8'd4, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
